apb_master_mux: RTL and testbench
=================================

// Module: apb_master_mux
// PURPOSE
//  Parametrised APB3 master that bridges a valid/ready request port to NUM_SLAVES APB slaves.
//  Decodes the target slave from the upper address bits and drives a one-hot PSEL.
//  Returns slave PSLVERR and a wait-state timeout error on a one-cycle response port.
//  Sits between the system-side command source and the APB slave fabric.
// PARAMETERS
//  ADDR_WIDTH      8   PADDR/req_addr width; must be > $clog2(NUM_SLAVES)
//  DATA_WIDTH      8   PWDATA/PRDATA width per slave
//  NUM_SLAVES      4   slave count; power of two, >= 2; SEL_BITS = $clog2(NUM_SLAVES)
//  TIMEOUT_CYCLES  16  max ACCESS cycles with PREADY low before abort; >= 1
// PORTS
//  PCLK         in   1                      clock, rising edge
//  PRESETn      in   1                      asynchronous, active-low reset
//  req_valid    in   1                      request present
//  req_ready    out  1                      request accepted when req_valid && req_ready
//  req_write    in   1                      1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH             transfer address
//  req_wdata    in   DATA_WIDTH             write data
//  rsp_valid    out  1                      one-cycle completion pulse
//  rsp_rdata    out  DATA_WIDTH             read data; 0 for writes and aborts
//  rsp_err      out  1                      PSLVERR of the addressed slave, or timeout
//  PADDR        out  ADDR_WIDTH             APB address
//  PWDATA       out  DATA_WIDTH             APB write data
//  PWRITE       out  1                      APB direction
//  PSEL         out  NUM_SLAVES             one-hot slave select
//  PENABLE      out  1                      APB access phase
//  PRDATA       in   NUM_SLAVES*DATA_WIDTH  slave i read data at [i*DATA_WIDTH +: DATA_WIDTH]
//  PREADY       in   NUM_SLAVES             per-slave ready
//  PSLVERR      in   NUM_SLAVES             per-slave error; sampled only when that slave completes
// BEHAVIOUR
//  - Reset (async, PRESETn low): state=IDLE; all outputs 0; PADDR/PWDATA=0; wait counter=0.
//  - All outputs are registered. req_ready = (state==IDLE) && !rsp_valid.
//  - FSM states: IDLE, SETUP, ACCESS.
//    IDLE: on accept, latch addr/wdata/write into PADDR/PWDATA/PWRITE; next state SETUP.
//    SETUP: PSEL[idx]=1, PENABLE=0; unconditionally go to ACCESS. idx = PADDR[ADDR_WIDTH-1 -: SEL_BITS].
//    ACCESS: PSEL[idx]=1, PENABLE=1.
//      PREADY[idx]=1: rsp_valid<=1, rsp_err<=PSLVERR[idx], rsp_rdata<=(PWRITE ? 0 : PRDATA slice); go to IDLE.
//      PREADY[idx]=0: wait counter +1. At TIMEOUT_CYCLES, abort: rsp_valid<=1, rsp_err<=1, rsp_rdata<=0; go to IDLE.
//  - rsp_valid is high for exactly the first IDLE cycle after completion. req_ready is low in that cycle.
//    Minimum transfer spacing is therefore 4 cycles, accept to accept.
//  - PADDR, PWDATA and PWRITE stay stable from SETUP through the end of ACCESS; they hold their last value in IDLE.
//  - PSEL/PENABLE are 0 in IDLE. PREADY/PSLVERR/PRDATA of non-selected slaves are ignored.
//  - The wait counter clears on entering SETUP. Its width is $clog2(TIMEOUT_CYCLES+1); it never wraps.
//  - Reset asserted mid-transfer: PSEL/PENABLE drop immediately; no response is issued for the lost transfer.
//  - req_* are ignored outside the accept cycle. The latched transfer is unaffected by later changes on req_*.
// STRUCTURE
//  - Shared package apb_pkg: state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the SEL_BITS derivation.
//  - One sub-module, apb_addr_decoder: combinational PADDR -> one-hot select vector and index.
//    Parametrised by ADDR_WIDTH and NUM_SLAVES; also reused by the slave-side interconnect.
//  - The FSM, wait counter and response registers live in this module.
// TESTING
//  - Write, zero waits: addr 0x45, wdata 0xA5, slave1 PREADY=1.
//    -> PSEL=0010 in SETUP; PENABLE in ACCESS; rsp_valid 1 cycle; rsp_err=0; rsp_rdata=0.
//  - Read with 3 waits: addr 0xC0 -> slave3; PREADY low for 3 ACCESS cycles; PRDATA3=0x5A.
//    -> ACCESS lasts 4 cycles; rsp_rdata=0x5A; PADDR stable throughout.
//  - Slave error: read slave0 with PREADY=1 and PSLVERR0=1.
//    -> rsp_err=1. A simultaneous PSLVERR2=1 from a non-selected slave does not affect rsp_err.
//  - Timeout: slave2 never raises PREADY.
//    -> abort after 16 ACCESS cycles; rsp_err=1; rsp_rdata=0; PSEL=0 on the next cycle; FSM back in IDLE.
//  - Back-to-back: req_valid held high with 3 queued requests.
//    -> accepts 4 cycles apart; req_ready low during SETUP, ACCESS and the rsp_valid cycle.
//  - Mid-transfer reset: PRESETn low during ACCESS.
//    -> all outputs 0 asynchronously; after release, the first request completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding and slave-select width derivation.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  function automatic int sel_bits(input int num_slaves);
    return $clog2(num_slaves);
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB address decoder: the top SEL_BITS of the address pick one slave,
// returned both as a one-hot select vector and as a binary index.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_SLAVES = 4,
  localparam int SEL_BITS  = sel_bits(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [SEL_BITS-1:0]   idx
);

  // Offset bits within a slave window are not part of the decode.
  logic unused_offset;
  assign unused_offset = ^addr[ADDR_WIDTH-SEL_BITS-1:0];

  assign idx = addr[ADDR_WIDTH-1 -: SEL_BITS];

  always_comb begin
    sel      = '0;
    sel[idx] = 1'b1;
  end

endmodule

// File: rtl/apb_master_mux.sv
// APB3 master bridging a valid/ready request port to NUM_SLAVES slaves, with
// per-transfer wait-state timeout and a one-cycle registered response.
module apb_master_mux
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  output logic                           rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  output logic                           PWRITE,
  output logic [NUM_SLAVES-1:0]          PSEL,
  output logic                           PENABLE,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]          PREADY,
  input  logic [NUM_SLAVES-1:0]          PSLVERR
);

  localparam int SEL_BITS = sel_bits(NUM_SLAVES);
  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_e             state, state_d;
  logic [CNT_W-1:0]       wait_cnt, wait_cnt_d;
  logic                   accept;
  logic [ADDR_WIDTH-1:0]  paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_d;
  logic                   pwrite_d;
  logic [NUM_SLAVES-1:0]  psel_d;
  logic                   penable_d;
  logic                   req_ready_d;
  logic                   rsp_valid_d;
  logic                   rsp_err_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_d;
  logic [NUM_SLAVES-1:0]  dec_sel;
  logic [SEL_BITS-1:0]    dec_idx;
  logic [DATA_WIDTH-1:0]  prdata_sel;

  // Address/data/direction capture; held unchanged outside the accept cycle.
  always_comb begin
    accept   = (state == IDLE) && req_valid && req_ready;
    paddr_d  = PADDR;
    pwdata_d = PWDATA;
    pwrite_d = PWRITE;
    if (accept) begin
      paddr_d  = req_addr;
      pwdata_d = req_wdata;
      pwrite_d = req_write;
    end
  end

  // Decoding the next-cycle address lets PSEL be registered at the accept edge;
  // during ACCESS paddr_d equals PADDR, so dec_idx names the active slave.
  apb_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_dec (
    .addr (paddr_d),
    .sel  (dec_sel),
    .idx  (dec_idx)
  );

  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dec_idx == SEL_BITS'(i)) prdata_sel = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d     = state;
    wait_cnt_d  = wait_cnt;
    penable_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY[dec_idx]) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR[dec_idx];
          rsp_rdata_d = PWRITE ? '0 : prdata_sel;
          state_d     = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          // Wait budget exhausted: abort with an error and no data.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          wait_cnt_d  = wait_cnt + 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
          penable_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    psel_d      = (state_d == IDLE) ? '0 : dec_sel;
    req_ready_d = (state_d == IDLE) && !rsp_valid_d;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_cnt_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      PWRITE    <= pwrite_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master_mux.sv
// Scoreboard bench for apb_master_mux: directed requests push expected responses,
// a negedge monitor pops and compares on every rsp_valid pulse.
module tb_apb_master_mux;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [7:0]  PADDR, PWDATA;
  logic        PWRITE, PENABLE;
  logic [3:0]  PSEL, PREADY, PSLVERR;
  logic [31:0] PRDATA;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] addr;
    logic       w;
    logic [7:0] wd;
    logic       err;
    logic [7:0] rd;
    logic [7:0] alen;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          wait_cfg[4];
  int          acc_cnt[4];
  logic [3:0]  err_cfg;
  logic [31:0] prdata_cfg;

  apb_master_mux dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave models: slave s raises PREADY after wait_cfg[s] low ACCESS cycles.
  always @(posedge PCLK) begin
    for (int s = 0; s < 4; s++)
      acc_cnt[s] <= (PSEL[s] && PENABLE && !PREADY[s]) ? acc_cnt[s] + 1 : 0;
  end

  always_comb begin
    PREADY = '0;
    for (int s = 0; s < 4; s++)
      PREADY[s] = PSEL[s] && PENABLE && (acc_cnt[s] >= wait_cfg[s]);
  end

  assign PSLVERR = err_cfg;
  assign PRDATA  = prdata_cfg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_PSEL"}, {28'd0, PSEL}, 32'd0);
    check({tag, "_PENABLE"}, {31'd0, PENABLE}, 32'd0);
    check({tag, "_PADDR"}, {24'd0, PADDR}, 32'd0);
    check({tag, "_PWDATA"}, {24'd0, PWDATA}, 32'd0);
    check({tag, "_PWRITE"}, {31'd0, PWRITE}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_rsp_rdata"}, {24'd0, rsp_rdata}, 32'd0);
  endtask

  // Presents a request, waits (bounded) for acceptance, records the expectation.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [3:0] esel, input logic ee, input logic [7:0] erd,
                       input int alen, input bit chk_gap);
    int n = 0;
    exp_t e;
    @(negedge PCLK);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    e.sel = esel; e.addr = a; e.w = w; e.wd = d; e.err = ee; e.rd = erd; e.alen = 8'(alen);
    q.push_back(e);
    if (chk_gap) check("accept_gap", cyc - last_acc, 32'd4);
    last_acc = cyc;
    @(posedge PCLK);
  endtask

  // Drops req_valid and scrambles req_* so a latched transfer must not follow them.
  task automatic idle();
    @(negedge PCLK);
    req_valid = 1'b0;
    req_addr  = ~req_addr;
    req_wdata = ~req_wdata;
    req_write = ~req_write;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge PCLK);
      #1;
      n++;
    end
    check("drain_timeout", q.size(), 32'd0);
  endtask

  logic [3:0] s_sel;
  logic [7:0] s_addr, s_wd;
  logic       s_w;
  int         acc_len;
  bit         unstable;

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      acc_len  = 0;
      unstable = 1'b0;
    end else begin
      if (PSEL != 4'd0) check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      if (PSEL != 4'd0 && !PENABLE) begin
        s_sel = PSEL; s_addr = PADDR; s_wd = PWDATA; s_w = PWRITE;
        acc_len = 0; unstable = 1'b0;
      end
      if (PENABLE) begin
        acc_len++;
        if (PADDR !== s_addr || PSEL !== s_sel || PWDATA !== s_wd || PWRITE !== s_w) unstable = 1'b1;
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rd});
          check("setup_psel", {28'd0, s_sel}, {28'd0, e.sel});
          check("paddr", {24'd0, s_addr}, {24'd0, e.addr});
          check("pwrite", {31'd0, s_w}, {31'd0, e.w});
          if (e.w) check("pwdata", {24'd0, s_wd}, {24'd0, e.wd});
          check("access_len", acc_len, {24'd0, e.alen});
          check("bus_stable", {31'd0, unstable}, 32'd0);
          check("psel_rsp_cycle", {28'd0, PSEL}, 32'd0);
          check("ready_rsp_cycle", {31'd0, req_ready}, 32'd0);
        end
      end
    end
  end

  initial begin
    int n;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    err_cfg = '0; prdata_cfg = '0;
    for (int s = 0; s < 4; s++) wait_cfg[s] = 0;

    #1 PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    outputs_zero("rst");
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Write, zero waits, slave1
    issue(1'b1, 8'h45, 8'hA5, 4'b0010, 1'b0, 8'h00, 1, 1'b0);
    idle(); drain();

    // Read slave3 with 3 waits
    wait_cfg[3] = 3; prdata_cfg = 32'h5A00_0000;
    issue(1'b0, 8'hC0, 8'h00, 4'b1000, 1'b0, 8'h5A, 4, 1'b0);
    idle(); drain();

    // Slave0 error with a non-selected error present
    wait_cfg[3] = 0; prdata_cfg = 32'h0000_0033; err_cfg = 4'b0101;
    issue(1'b0, 8'h10, 8'h00, 4'b0001, 1'b1, 8'h33, 1, 1'b0);
    idle(); drain();

    // Only a non-selected slave flags an error
    prdata_cfg = 32'h0000_7700; err_cfg = 4'b0100;
    issue(1'b0, 8'h50, 8'h00, 4'b0010, 1'b0, 8'h77, 1, 1'b0);
    idle(); drain();

    // Timeout on slave2
    err_cfg = 4'b0000; wait_cfg[2] = 1000; prdata_cfg = 32'h00EE_0000;
    issue(1'b0, 8'h80, 8'h00, 4'b0100, 1'b1, 8'h00, 16, 1'b0);
    idle(); drain();
    @(negedge PCLK);
    check("timeout_psel_idle", {28'd0, PSEL}, 32'd0);
    check("timeout_ready_idle", {31'd0, req_ready}, 32'd1);

    // Back-to-back with req_valid held high
    wait_cfg[2] = 0; prdata_cfg = 32'h0000_6200;
    issue(1'b1, 8'h11, 8'h01, 4'b0001, 1'b0, 8'h00, 1, 1'b0);
    issue(1'b0, 8'h62, 8'hFF, 4'b0010, 1'b0, 8'h62, 1, 1'b1);
    issue(1'b1, 8'hF3, 8'h3C, 4'b1000, 1'b0, 8'h00, 1, 1'b1);
    idle(); drain();

    // Reset during ACCESS
    wait_cfg[3] = 10;
    issue(1'b0, 8'hC4, 8'h00, 4'b1000, 1'b0, 8'h00, 0, 1'b0);
    idle();
    n = 0;
    while (!PENABLE && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    check("mid_access_reached", {31'd0, PENABLE}, 32'd1);
    #2 PRESETn = 1'b0;
    #1 outputs_zero("mid_rst");
    q.delete();
    repeat (2) @(negedge PCLK);
    check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    PRESETn = 1'b1;
    wait_cfg[3] = 0;
    issue(1'b1, 8'h05, 8'h99, 4'b0001, 1'b0, 8'h00, 1, 1'b0);
    idle(); drain();

    repeat (2) @(negedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
